vector_mem_aligner: RTL and testbench

VECTOR_MEM_ALIGNER -- requirements
Module: vector_mem_aligner

---
 rtl/vector_mem_aligner.sv | 219 +++++++++++++++++++++
 tb/tb_vector_mem_aligner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_aligner.sv
// vector_mem_aligner
//   Turns a scalar (1/2/4 byte) or vector (one full line) load/store at an
//   arbitrary byte address into one or two line-wide memory beats, and
//   realigns read data back into register order.
//
// Ports
//   clk, rst         : clock, asynchronous active-low reset
//   memtoRegM        : read request          memWriteM  : write request
//   memSrcM          : 1 = vector, 0 = scalar
//   memSizeM         : scalar size 00=1B, 01=2B, 1x=4B
//   memSignedM       : sign-extend scalar reads
//   address          : byte address
//   scalarDataIn     : scalar store data     vectorDataIn : vector store data
//   readData         : memory q (one cycle after rden)
//   busy             : pipeline stall        rdValid      : read result valid
//   scalarDataOut    : scalar read result    vectorDataOut: vector read result
//   rden, wren       : memory strobes        ip_address   : memory line index
//   byteena          : byte enables          writeData    : memory write data
module vector_mem_aligner #(
  parameter int LINE_W    = 256,
  parameter int SCALAR_W  = 32,
  parameter int ADDR_W    = 32,
  parameter int IP_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   memtoRegM,
  input  logic                   memWriteM,
  input  logic                   memSrcM,
  input  logic [1:0]             memSizeM,
  input  logic                   memSignedM,
  input  logic [ADDR_W-1:0]      address,
  input  logic [SCALAR_W-1:0]    scalarDataIn,
  input  logic [LINE_W-1:0]      vectorDataIn,
  input  logic [LINE_W-1:0]      readData,
  output logic                   busy,
  output logic                   rdValid,
  output logic [SCALAR_W-1:0]    scalarDataOut,
  output logic [LINE_W-1:0]      vectorDataOut,
  output logic                   rden,
  output logic                   wren,
  output logic [IP_ADDR_W-1:0]   ip_address,
  output logic [LINE_W/8-1:0]    byteena,
  output logic [LINE_W-1:0]      writeData
);

  localparam int LINE_BYTES = LINE_W / 8;
  localparam int OFF_W      = $clog2(LINE_BYTES);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BEAT0 = 3'd1;
  localparam logic [2:0] BEAT1 = 3'd2;
  localparam logic [2:0] CAP   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]           state_reg, state_next;
  logic                 write_reg, vec_reg, signed_reg;
  logic [1:0]           size_reg;
  logic [OFF_W-1:0]     off_reg;
  logic [IP_ADDR_W-1:0] line_reg;
  logic [LINE_W-1:0]    data_reg;
  logic [LINE_W-1:0]    buf_reg;
  logic [SCALAR_W-1:0]  scalar_out_reg;
  logic [LINE_W-1:0]    vector_out_reg;

  logic                 req;
  logic [OFF_W:0]       nbytes;
  logic [OFF_W+1:0]     end_pos;
  logic                 split;
  logic [2*LINE_BYTES-1:0] mask_wide;
  logic [2*LINE_W-1:0]  data_wide;
  logic [2*LINE_W-1:0]  wd_wide;
  logic [2*LINE_W-1:0]  rd_pair;
  logic [2*LINE_W-1:0]  rd_shift;
  logic [LINE_W-1:0]    rd_raw;
  logic [SCALAR_W-1:0]  scalar_val;
  logic                 sign_bit;
  int                   sbits;

  assign req = memtoRegM | memWriteM;

  // Access width and end position (exclusive) measured from byte 0 of line L.
  always_comb begin
    nbytes = '0;
    if (vec_reg) begin
      nbytes = (OFF_W+1)'(LINE_BYTES);
    end else begin
      case (size_reg)
        2'b00:   nbytes = (OFF_W+1)'(1);
        2'b01:   nbytes = (OFF_W+1)'(2);
        default: nbytes = (OFF_W+1)'(4);
      endcase
    end
  end

  assign end_pos = {2'b00, off_reg} + {1'b0, nbytes};
  assign split   = end_pos > (OFF_W+2)'(LINE_BYTES);

  // Data and byte mask laid out across the two-line window {L+1, L}.
  assign data_wide = {{LINE_W{1'b0}}, data_reg} << {off_reg, 3'b000};

  generate
    for (genvar gi = 0; gi < 2*LINE_BYTES; gi++) begin : g_bytes
      assign mask_wide[gi] = ((OFF_W+2)'(gi) >= {2'b00, off_reg}) &&
                             ((OFF_W+2)'(gi) < end_pos);
      // Bytes outside the access are forced to zero (scalar data is wider
      // than a 1/2 byte access).
      assign wd_wide[8*gi +: 8] = mask_wide[gi] ? data_wide[8*gi +: 8] : 8'h00;
    end
  endgenerate

  // Read realignment: line L is in the buffer for split accesses, otherwise
  // it is the live memory output.
  assign rd_pair  = split ? {readData, buf_reg} : {{LINE_W{1'b0}}, readData};
  assign rd_shift = rd_pair >> {off_reg, 3'b000};
  assign rd_raw   = rd_shift[LINE_W-1:0];

  always_comb begin
    case (size_reg)
      2'b00:   begin sbits = 8;  sign_bit = rd_raw[7];  end
      2'b01:   begin sbits = 16; sign_bit = rd_raw[15]; end
      default: begin sbits = 32; sign_bit = rd_raw[31]; end
    endcase
    scalar_val = '0;
    for (int b = 0; b < SCALAR_W; b++) begin
      scalar_val[b] = (b < sbits) ? rd_raw[b] : (signed_reg & sign_bit);
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = BEAT0;
      BEAT0:   state_next = split ? BEAT1 : (write_reg ? DONE : CAP);
      BEAT1:   state_next = write_reg ? DONE : CAP;
      CAP:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      write_reg      <= 1'b0;
      vec_reg        <= 1'b0;
      signed_reg     <= 1'b0;
      size_reg       <= 2'b00;
      off_reg        <= '0;
      line_reg       <= '0;
      data_reg       <= '0;
      buf_reg        <= '0;
      scalar_out_reg <= '0;
      vector_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req) begin
        write_reg  <= memWriteM;  // a simultaneous read+write is a write
        vec_reg    <= memSrcM;
        signed_reg <= memSignedM;
        size_reg   <= memSizeM;
        off_reg    <= address[OFF_W-1:0];
        line_reg   <= address[OFF_W +: IP_ADDR_W];
        data_reg   <= memSrcM ? vectorDataIn : LINE_W'(scalarDataIn);
      end
      if (state_reg == BEAT1 && !write_reg) begin
        buf_reg <= readData;  // q of the BEAT0 read (line L)
      end
      if (state_reg == CAP) begin
        if (vec_reg) vector_out_reg <= rd_raw;
        else         scalar_out_reg <= scalar_val;
      end
    end
  end

  // Memory side is a pure decode of the state and the latched request, so
  // an asynchronous reset drops the strobes immediately.
  always_comb begin
    rden       = 1'b0;
    wren       = 1'b0;
    ip_address = '0;
    byteena    = '0;
    writeData  = '0;
    if (state_reg == BEAT0 || state_reg == BEAT1) begin
      rden = ~write_reg;
      wren = write_reg;
      if (state_reg == BEAT0) begin
        ip_address = line_reg;
        if (write_reg) begin
          byteena   = mask_wide[LINE_BYTES-1:0];
          writeData = wd_wide[LINE_W-1:0];
        end else begin
          byteena   = '1;
        end
      end else begin
        ip_address = line_reg + 1'b1;  // wraps modulo 2^IP_ADDR_W
        if (write_reg) begin
          byteena   = mask_wide[2*LINE_BYTES-1:LINE_BYTES];
          writeData = wd_wide[2*LINE_W-1:LINE_W];
        end else begin
          byteena   = '1;
        end
      end
    end
  end

  always_comb begin
    case (state_reg)
      IDLE:    busy = rst & req;
      DONE:    busy = 1'b0;
      default: busy = 1'b1;
    endcase
  end

  assign rdValid       = (state_reg == DONE) && !write_reg;
  assign scalarDataOut = scalar_out_reg;
  assign vectorDataOut = vector_out_reg;

endmodule

// File: tb/tb_vector_mem_aligner.sv
module tb_vector_mem_aligner;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         memtoRegM = 1'b0;
  logic         memWriteM = 1'b0;
  logic         memSrcM = 1'b0;
  logic [1:0]   memSizeM = 2'b00;
  logic         memSignedM = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  scalarDataIn = '0;
  logic [255:0] vectorDataIn = '0;
  logic [255:0] readData = '0;
  logic         busy, rdValid;
  logic [31:0]  scalarDataOut;
  logic [255:0] vectorDataOut;
  logic         rden, wren;
  logic [13:0]  ip_address;
  logic [31:0]  byteena;
  logic [255:0] writeData;

  vector_mem_aligner dut (
    .clk(clk), .rst(rst),
    .memtoRegM(memtoRegM), .memWriteM(memWriteM), .memSrcM(memSrcM),
    .memSizeM(memSizeM), .memSignedM(memSignedM), .address(address),
    .scalarDataIn(scalarDataIn), .vectorDataIn(vectorDataIn),
    .readData(readData), .busy(busy), .rdValid(rdValid),
    .scalarDataOut(scalarDataOut), .vectorDataOut(vectorDataOut),
    .rden(rden), .wren(wren), .ip_address(ip_address),
    .byteena(byteena), .writeData(writeData)
  );

  always #5 clk = ~clk;

  // Line-wide memory attached to the DUT.
  logic [255:0] mem_lines [int];

  always @(posedge clk) begin
    if (wren) begin
      logic [255:0] line;
      line = mem_lines.exists(int'(ip_address)) ? mem_lines[int'(ip_address)] : '0;
      for (int k = 0; k < 32; k++)
        if (byteena[k]) line[8*k +: 8] = writeData[8*k +: 8];
      mem_lines[int'(ip_address)] = line;
    end
    if (rden)
      readData <= mem_lines.exists(int'(ip_address)) ? mem_lines[int'(ip_address)] : '0;
  end

  // Reference model: flat byte-addressed store over the 2^19-byte space.
  logic [7:0] ref_mem [int];
  logic [255:0] hold_vec;
  logic [31:0]  hold_scalar;

  int n_checks = 0;
  int n_miss   = 0;
  int n_ops    = 0;

  // Per-beat observations of the most recent run_op (cycles 2 and 3).
  logic         beat_rd [2];
  logic         beat_wr [2];
  logic [13:0]  beat_ip [2];
  logic [31:0]  beat_be [2];
  logic [255:0] beat_wd [2];

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_get(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic int acc_bytes(input bit vec, input logic [1:0] size);
    if (vec) return 32;
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  task automatic run_op(input bit wr, input bit rd, input bit vec, input logic [1:0] size,
                        input bit sgn, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [255:0] vdata);
    int cycles, n, exp_lat;
    bit done, split, is_wr;
    logic [255:0] data, v;
    logic [31:0] s;
    @(negedge clk);
    memWriteM = wr; memtoRegM = rd; memSrcM = vec; memSizeM = size;
    memSignedM = sgn; address = addr; scalarDataIn = sdata; vectorDataIn = vdata;
    #1;
    check_val("busy_accept", busy, 1'b1);
    for (int i = 0; i < 2; i++) begin
      beat_rd[i] = 0; beat_wr[i] = 0; beat_ip[i] = '0; beat_be[i] = '0; beat_wd[i] = '0;
    end
    cycles = 1; done = 0;
    while (!done && cycles < 12) begin
      @(posedge clk); #1;
      cycles++;
      if (cycles <= 3) begin
        beat_rd[cycles-2] = rden; beat_wr[cycles-2] = wren; beat_ip[cycles-2] = ip_address;
        beat_be[cycles-2] = byteena; beat_wd[cycles-2] = writeData;
      end
      if (!busy) done = 1;
    end
    memWriteM = 0; memtoRegM = 0;
    if (!done) check_val("timeout", 1'b0, 1'b1);
    is_wr = wr;
    n = acc_bytes(vec, size);
    split = (int'(addr[4:0]) + n) > 32;
    exp_lat = (is_wr ? 3 : 4) + (split ? 1 : 0);
    check_val("latency", cycles, exp_lat);
    check_val("rdValid_done", rdValid, !is_wr);
    check_val("beat0_strobe", {beat_wr[0], beat_rd[0]}, {is_wr, !is_wr});
    check_val("beat0_ip", beat_ip[0], addr[18:5]);
    if (is_wr) begin
      data = vec ? vdata : {224'h0, sdata};
      for (int j = 0; j < n; j++) ref_mem[int'((addr + j) & 32'h7FFFF)] = data[8*j +: 8];
      check_val("hold_vec", vectorDataOut, hold_vec);
      check_val("hold_scalar", scalarDataOut, hold_scalar);
    end else begin
      v = '0;
      for (int j = 0; j < n; j++) v[8*j +: 8] = ref_get(int'((addr + j) & 32'h7FFFF));
      if (vec) begin
        hold_vec = v;
        check_val("vector_rd", vectorDataOut, v);
      end else begin
        s = v[31:0];
        if (sgn && v[8*n-1]) for (int b = 8*n; b < 32; b++) s[b] = 1'b1;
        hold_scalar = s;
        check_val("scalar_rd", scalarDataOut, s);
      end
    end
    n_ops++;
    $display("op %0d: %s %s size=%0d sgn=%0d addr=%h split=%0d lat=%0d", n_ops,
             is_wr ? "WR" : "RD", vec ? "vec" : "scl", size, sgn, addr, split, cycles);
    @(posedge clk); #1;
    check_val("rdValid_idle", rdValid, 1'b0);
  endtask

  initial begin
    logic [255:0] vv, xx, aa;
    hold_vec = '0; hold_scalar = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_strobes", {rden, wren, rdValid}, 3'b000);
    check_val("rst_ip", ip_address, 14'h0);
    check_val("rst_byteena", byteena, 32'h0);
    check_val("rst_wdata", writeData, 256'h0);
    check_val("rst_scalar", scalarDataOut, 32'h0);
    check_val("rst_vector", vectorDataOut, 256'h0);
    @(negedge clk); rst = 1'b1;

    // Split word write across lines 0/1.
    run_op(1, 0, 0, 2'b10, 0, 32'h1E, 32'hA1B2C3D4, '0);
    check_val("w35_be0", beat_be[0], 32'hC0000000);
    check_val("w35_wd0", beat_wd[0], {16'hC3D4, 240'h0});
    check_val("w35_ip1", beat_ip[1], 14'd1);
    check_val("w35_be1", beat_be[1], 32'h00000003);
    check_val("w35_wd1", beat_wd[1], {240'h0, 16'hA1B2});

    // Split vector write at 0x30.
    vv = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_op(1, 0, 1, 2'b00, 0, 32'h30, '0, vv);
    check_val("w36_be0", beat_be[0], 32'hFFFF0000);
    check_val("w36_wd0", beat_wd[0], {vv[127:0], 128'h0});
    check_val("w36_ip1", beat_ip[1], 14'd2);
    check_val("w36_be1", beat_be[1], 32'h0000FFFF);
    check_val("w36_wd1", beat_wd[1], {128'h0, vv[255:128]});

    // Aligned vector read of line 2.
    xx = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_op(1, 0, 1, 2'b00, 0, 32'h40, '0, xx);
    run_op(0, 1, 1, 2'b00, 0, 32'h40, '0, '0);
    check_val("r37_be0", beat_be[0], 32'hFFFFFFFF);
    check_val("r37_wd0", beat_wd[0], 256'h0);
    check_val("r37_vec", vectorDataOut, xx);

    // Split vector read across lines 1/2.
    aa = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    run_op(1, 0, 1, 2'b00, 0, 32'h20, '0, aa);
    run_op(0, 1, 1, 2'b00, 0, 32'h30, '0, '0);
    check_val("r38_vec", vectorDataOut, {xx[127:0], aa[255:128]});

    // Byte read with and without sign extension.
    run_op(1, 0, 0, 2'b00, 0, 32'h05, 32'h5A5A5A80, '0);
    run_op(0, 1, 0, 2'b00, 1, 32'h05, '0, '0);
    check_val("r39_signed", scalarDataOut, 32'hFFFFFF80);
    run_op(0, 1, 0, 2'b00, 0, 32'h05, '0, '0);
    check_val("r39_unsigned", scalarDataOut, 32'h00000080);

    // Randomized traffic in a small window so reads hit written bytes.
    for (int t = 0; t < 200; t++) begin
      bit wr, rd;
      wr = $urandom_range(0, 1);
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      run_op(wr, rd, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)),
             $urandom_range(0, 1), $urandom_range(0, 32'h17F), $urandom,
             {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    end

    // Split write at the top line wraps to line 0; reset during BEAT1.
    @(negedge clk);
    memWriteM = 1; memtoRegM = 0; memSrcM = 0; memSizeM = 2'b10;
    address = 32'h7FFFE; scalarDataIn = 32'h11223344;
    @(posedge clk); #1;
    check_val("w40_ip0", ip_address, 14'h3FFF);
    check_val("w40_wren0", wren, 1'b1);
    @(posedge clk); #1;
    check_val("w40_ip1", ip_address, 14'h0000);
    check_val("w40_be1", byteena, 32'h00000003);
    #1 rst = 1'b0;
    #1;
    check_val("w40_rst_wren", wren, 1'b0);
    check_val("w40_rst_busy", busy, 1'b0);
    check_val("w40_rst_rdvalid", rdValid, 1'b0);
    check_val("w40_rst_scalar", scalarDataOut, 32'h0);
    check_val("w40_rst_vector", vectorDataOut, 256'h0);
    // Only the BEAT0 half reached memory.
    ref_mem[32'h7FFFE] = 8'h44;
    ref_mem[32'h7FFFF] = 8'h33;
    hold_vec = '0; hold_scalar = '0;
    @(negedge clk); memWriteM = 0;
    @(negedge clk); rst = 1'b1;
    run_op(0, 1, 0, 2'b10, 0, 32'h7FFFE, '0, '0);
    run_op(1, 0, 0, 2'b10, 0, 32'h100, 32'hDEADBEEF, '0);
    run_op(0, 1, 0, 2'b10, 0, 32'h100, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_miss);
    $finish;
  end

endmodule
